// File: rtl/srio_pkt_chk_pkg.sv
// srio_pkt_chk_pkg: shared types and constants for the SRIO packet checker.
package srio_pkt_chk_pkg;
    localparam logic [3:0] FTYPE_NREAD  = 4'd2;
    localparam logic [3:0] FTYPE_NWRITE = 4'd5;
    localparam logic [3:0] FTYPE_SWRITE = 4'd6;
    localparam logic [3:0] FTYPE_RESP   = 4'd13;
    localparam int MAX_BEATS = 33;

    typedef enum logic {ST_HDR, ST_PAYLOAD} state_e;

    typedef struct packed {
        logic [7:0]  tid;
        logic [3:0]  ftype;
        logic [3:0]  ttype;
        logic [7:0]  size;
        logic [15:0] src;
        logic [15:0] dst;
        logic [5:0]  beats;
        logic [2:0]  err;
    } rec_t;
endpackage

// File: rtl/srio_pkt_chk_if.sv
// srio_pkt_chk_if: tapped AXI4-Stream HELLO channel; the checker only ever listens.
interface srio_pkt_chk_if;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [31:0] tuser;
    modport master (output tvalid, tready, tlast, tdata, tkeep, tuser);
    modport slave  (input  tvalid, tready, tlast, tdata, tkeep, tuser);
endinterface

// File: rtl/srio_pkt_chk_fifo.sv
// srio_pkt_chk_fifo: record FIFO with extra pointer MSB for full/empty; a push is accepted when full if a pop happens in the same cycle.
module srio_pkt_chk_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 65
) (
    input  logic         log_clk,
    input  logic         log_rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         we, re;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign re    = pop && !empty;
    assign we    = push && (!full || re);
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    // Pointer update; MSB distinguishes full from empty.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (we) wp <= wp + 1'b1;
            if (re) rp <= rp + 1'b1;
        end
    end

    // Storage needs no reset: unread entries are masked by empty.
    always_ff @(posedge log_clk) begin
        if (we) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/srio_pkt_checker.sv
// srio_pkt_checker: passive HELLO stream tap that checks each packet and queues one record per packet.
// Define SRIO_PKT_CHK_DISPLAY_EN to print every completed record in simulation.
module srio_pkt_checker
    import srio_pkt_chk_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NAME = 0
) (
    input  logic          log_clk,
    input  logic          log_rst,
    srio_pkt_chk_if.slave axis,
    output logic          hdr_valid,
    input  logic          hdr_ready,
    output logic [7:0]    hdr_tid,
    output logic [7:0]    hdr_size,
    output logic [3:0]    hdr_ftype,
    output logic [3:0]    hdr_ttype,
    output logic [15:0]   hdr_src,
    output logic [15:0]   hdr_dst,
    output logic [5:0]    hdr_beats,
    output logic [2:0]    hdr_err,
    output logic [31:0]   pkt_count,
    output logic [15:0]   err_count,
    output logic [15:0]   drop_count
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || NAME < 0) begin : g_bad_cfg
        $error("srio_pkt_checker: FIFO_DEPTH must be a power of two >= 2 and NAME non-negative");
    end

    state_e      state_q, state_d;
    rec_t        rec, fifo_out;
    logic [7:0]  tid_q, size_q;
    logic [3:0]  ftype_q, ttype_q;
    logic [15:0] src_q, dst_q;
    logic [5:0]  beats_q;
    logic [8:0]  exp_beats;
    logic        kerr_q, kerr, beat, done, in_hdr, full, empty, pop;

    assign beat      = axis.tvalid && axis.tready;
    assign done      = beat && axis.tlast;
    assign in_hdr    = state_q == ST_HDR;
    assign hdr_valid = !empty;
    assign pop       = hdr_valid && hdr_ready;

    // Next state, and the record as it stands if the current beat ends the packet.
    always_comb begin
        state_d = state_q;
        if (beat) state_d = axis.tlast ? ST_HDR : ST_PAYLOAD;
        rec.tid   = in_hdr ? axis.tdata[63:56] : tid_q;
        rec.ftype = in_hdr ? axis.tdata[55:52] : ftype_q;
        rec.ttype = in_hdr ? axis.tdata[51:48] : ttype_q;
        rec.size  = in_hdr ? axis.tdata[43:36] : size_q;
        rec.src   = in_hdr ? axis.tuser[31:16] : src_q;
        rec.dst   = in_hdr ? axis.tuser[15:0] : dst_q;
        rec.beats = in_hdr ? 6'd1 : (beats_q == 6'd63 ? beats_q : beats_q + 6'd1);
        kerr      = (!in_hdr && kerr_q) || (!axis.tlast && axis.tkeep != 8'hFF);
        exp_beats = 9'd1 + ((9'(rec.size) + 9'd8) >> 3);
        rec.err   = {rec.beats > 6'(MAX_BEATS), kerr,
                     (rec.ftype == FTYPE_NWRITE || rec.ftype == FTYPE_SWRITE) && 9'(rec.beats) != exp_beats};
    end

    // FSM state register; reset discards any partial packet.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) state_q <= ST_HDR;
        else state_q <= state_d;
    end

    // Running header capture, beat count and tkeep error for the packet in flight.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            {tid_q, ftype_q, ttype_q, size_q, src_q, dst_q, beats_q} <= '0;
            kerr_q <= 1'b0;
        end else if (beat) begin
            {tid_q, ftype_q, ttype_q, size_q, src_q, dst_q, beats_q} <=
                {rec.tid, rec.ftype, rec.ttype, rec.size, rec.src, rec.dst, rec.beats};
            kerr_q <= kerr;
        end
    end

    // Packet, error and drop statistics, updated as each packet completes.
    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            pkt_count  <= '0;
            err_count  <= '0;
            drop_count <= '0;
        end else if (done) begin
            pkt_count <= pkt_count + 32'd1;
            if (rec.err != 3'd0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (full && !pop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    srio_pkt_chk_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(rec_t))) u_fifo (
        .log_clk (log_clk),
        .log_rst (log_rst),
        .push    (done),
        .din     (rec),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .dout    (fifo_out)
    );

    assign hdr_tid   = fifo_out.tid;
    assign hdr_ftype = fifo_out.ftype;
    assign hdr_ttype = fifo_out.ttype;
    assign hdr_size  = fifo_out.size;
    assign hdr_src   = fifo_out.src;
    assign hdr_dst   = fifo_out.dst;
    assign hdr_beats = fifo_out.beats;
    assign hdr_err   = fifo_out.err;

`ifdef SRIO_PKT_CHK_DISPLAY_EN
    // Simulation-only trace of every completed packet.
    always @(posedge log_clk) begin
        if (!log_rst && done)
            $display("%s @%0t tid=%h ftype=%h ttype=%h size=%h src=%h dst=%h beats=%0d err=%b%s",
                     NAME == 0 ? "IREQ" : NAME == 1 ? "IRESP" : NAME == 4 ? "TRESP" : NAME == 5 ? "TREQ" : "CHAN",
                     $time, rec.tid, rec.ftype, rec.ttype, rec.size, rec.src, rec.dst, rec.beats, rec.err,
                     rec.err != 3'd0 ? " ERROR" : "");
    end
`endif
endmodule

// File: tb/tb_srio_pkt_checker.sv
// tb_srio_pkt_checker: randomized and directed packets against a packet-level reference model with a record scoreboard.
module tb_srio_pkt_checker;
    import srio_pkt_chk_pkg::*;

    localparam int DEPTH = 8;

    logic        log_clk = 1'b0;
    logic        log_rst = 1'b1;
    logic        hdr_valid, hdr_ready;
    logic [7:0]  hdr_tid, hdr_size;
    logic [3:0]  hdr_ftype, hdr_ttype;
    logic [15:0] hdr_src, hdr_dst;
    logic [5:0]  hdr_beats;
    logic [2:0]  hdr_err;
    logic [31:0] pkt_count;
    logic [15:0] err_count, drop_count;

    int   checks = 0, failures = 0;
    int   exp_pkt = 0, exp_err = 0, exp_drop = 0;
    rec_t exp_q[$];

    srio_pkt_chk_if axis();

    srio_pkt_checker #(.FIFO_DEPTH(DEPTH), .NAME(0)) dut (
        .log_clk    (log_clk),
        .log_rst    (log_rst),
        .axis       (axis),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .hdr_tid    (hdr_tid),
        .hdr_size   (hdr_size),
        .hdr_ftype  (hdr_ftype),
        .hdr_ttype  (hdr_ttype),
        .hdr_src    (hdr_src),
        .hdr_dst    (hdr_dst),
        .hdr_beats  (hdr_beats),
        .hdr_err    (hdr_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count),
        .drop_count (drop_count)
    );

    always #5 log_clk = ~log_clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every popped record must match the oldest expected one.
    always @(negedge log_clk) begin
        if (!log_rst && hdr_valid && hdr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record: got tid=%h beats=%0d err=%b expected none", hdr_tid, hdr_beats, hdr_err);
            end else begin
                chk("record", {hdr_tid, hdr_ftype, hdr_ttype, hdr_size, hdr_src, hdr_dst, hdr_beats, hdr_err},
                    exp_q.pop_front());
            end
        end
    end

    // A cycle that is deliberately not a beat, with random data on the bus.
    task automatic idle_cycle();
        axis.tvalid = 1'($urandom_range(0, 1));
        axis.tready = axis.tvalid ? 1'b0 : 1'($urandom_range(0, 1));
        axis.tlast  = 1'($urandom_range(0, 1));
        axis.tdata  = {$urandom, $urandom};
        axis.tkeep  = 8'($urandom);
        axis.tuser  = $urandom;
        @(posedge log_clk);
        #1;
    endtask

    // Send one packet of n beats; the reference record comes from the packet's own description.
    task automatic send_pkt(input logic [7:0] tid, input logic [3:0] ft, input logic [3:0] tt,
                            input logic [7:0] sz, input logic [31:0] tu, input int n, input int bad, input bit stall);
        rec_t       r;
        logic [7:0] k;
        bit         kerr = 0;
        int         exp_n = 1 + (int'(sz) + 8) / 8;
        for (int b = 0; b < n; b++) begin
            k = (b == bad) ? 8'h0F : 8'hFF;
            if (b < n - 1 && k != 8'hFF) kerr = 1;
            while (stall && $urandom_range(0, 2) == 0) idle_cycle();
            axis.tvalid = 1'b1;
            axis.tready = 1'b1;
            axis.tlast  = (b == n - 1);
            axis.tkeep  = k;
            axis.tdata  = {$urandom, $urandom};
            axis.tuser  = $urandom;
            if (b == 0) begin
                axis.tdata[63:56] = tid;
                axis.tdata[55:52] = ft;
                axis.tdata[51:48] = tt;
                axis.tdata[43:36] = sz;
                axis.tuser = tu;
            end
            if (b == n - 1) begin
                r.tid   = tid;
                r.ftype = ft;
                r.ttype = tt;
                r.size  = sz;
                r.src   = tu[31:16];
                r.dst   = tu[15:0];
                r.beats = 6'(n > 63 ? 63 : n);
                r.err   = {n > 33, kerr, (ft == 4'd5 || ft == 4'd6) && n != exp_n};
                exp_pkt++;
                if (r.err != 3'd0) exp_err++;
                if (!hdr_ready && exp_q.size() >= DEPTH) exp_drop++;
                else exp_q.push_back(r);
            end
            @(posedge log_clk);
            #1;
        end
        axis.tvalid = 1'b0;
        axis.tready = 1'b0;
    endtask

    task automatic drain();
        hdr_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge log_clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d records still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge log_clk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
        repeat (2) @(posedge log_clk);
        #1;
        chk({tag, "_pkt_count"}, 65'(pkt_count), 65'(exp_pkt));
        chk({tag, "_err_count"}, 65'(err_count), 65'(exp_err));
        chk({tag, "_drop_count"}, 65'(drop_count), 65'(exp_drop));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hdr"}, {hdr_valid, hdr_tid, hdr_ftype, hdr_ttype, hdr_size, hdr_src, hdr_dst, hdr_beats, hdr_err}, '0);
        chk({tag, "_counts"}, 65'({pkt_count, err_count, drop_count}), '0);
    endtask

    initial begin
        int n, sz, ft, bad;
        hdr_ready   = 1'b1;
        axis.tvalid = 1'b0;
        axis.tready = 1'b0;
        axis.tlast  = 1'b0;
        axis.tdata  = '0;
        axis.tkeep  = '0;
        axis.tuser  = '0;
        repeat (3) @(posedge log_clk);
        #1;
        chk_all_zero("reset");
        log_rst = 1'b0;
        repeat (2) idle_cycle();

        send_pkt(8'h3C, 4'd5, 4'd4, 8'h07, 32'h0001_0002, 2, -1, 0);
        drain();
        chk_counters("nwrite");
        send_pkt(8'h11, 4'd5, 4'd4, 8'h0F, 32'h1234_5678, 2, -1, 0);
        drain();
        chk_counters("short_nwrite");
        send_pkt(8'h22, 4'd2, 4'd4, 8'h00, 32'hAAAA_5555, 1, -1, 1);
        send_pkt(8'h33, 4'd6, 4'd0, 8'h0F, 32'h0003_0004, 3, 0, 0);
        send_pkt(8'h34, 4'd6, 4'd0, 8'h0F, 32'h0005_0006, 3, 2, 1);
        send_pkt(8'h40, 4'd5, 4'd1, 8'hFF, 32'h0007_0008, 33, -1, 0);
        send_pkt(8'h41, 4'd5, 4'd1, 8'hFF, 32'h0009_000A, 34, -1, 0);
        send_pkt(8'h42, 4'd2, 4'd4, 8'h10, 32'h000B_000C, 70, -1, 0);
        for (int i = 0; i < 6; i++) send_pkt(8'(8'h50 + i), 4'd13, 4'd8, 8'h00, $urandom, 1, -1, 0);
        drain();
        chk_counters("directed");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: ft = 2;
                1: ft = 5;
                2: ft = 6;
                3: ft = 13;
                default: ft = int'($urandom_range(0, 15));
            endcase
            sz  = int'($urandom_range(0, 255));
            n   = $urandom_range(0, 1) ? 1 + (sz + 8) / 8 : int'($urandom_range(1, 36));
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            send_pkt(8'($urandom), 4'(ft), 4'($urandom), 8'(sz), $urandom, n, bad, 1'($urandom_range(0, 1)));
        end
        drain();
        chk_counters("random");

        hdr_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_pkt(8'(i), 4'd2, 4'd4, 8'h00, 32'h0000_0001, 1, -1, 0);
        repeat (3) @(posedge log_clk);
        #1;
        chk("full_valid_tid", {hdr_valid, hdr_tid}, {1'b1, 8'h00});
        chk("full_drop_count", 65'(drop_count), 65'(exp_drop));
        repeat (7) @(posedge log_clk);
        #1;
        chk("full_hold_tid", {hdr_valid, hdr_tid}, {1'b1, exp_q[0].tid});
        hdr_ready = 1'b1;
        send_pkt(8'h09, 4'd2, 4'd4, 8'h00, 32'h0000_0001, 1, -1, 0);
        drain();
        chk_counters("fifo_full");

        axis.tvalid = 1'b1;
        axis.tready = 1'b1;
        axis.tlast  = 1'b0;
        axis.tkeep  = 8'hFF;
        axis.tdata  = {8'h77, 4'd5, 4'd0, 4'd0, 8'h0F, 36'd0};
        axis.tuser  = 32'hDEAD_BEEF;
        repeat (2) @(posedge log_clk);
        #1;
        axis.tvalid = 1'b0;
        log_rst = 1'b1;
        #1;
        exp_pkt = 0;
        exp_err = 0;
        exp_drop = 0;
        chk_all_zero("mid_reset");
        @(posedge log_clk);
        #1;
        log_rst = 1'b0;
        send_pkt(8'h5A, 4'd5, 4'd1, 8'h07, 32'h0010_0020, 2, -1, 0);
        drain();
        chk_counters("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
